frame_sync_controller: RTL and testbench
========================================

Name: frame_sync_controller

Overview:
Sequences reception of one BEP frame on the decoded Manchester bit stream.
- Hunts for a fixed preamble and emits transmission_begin to reset the downstream shift/multiplex stage.
- Gates payload bits to that stage and counts them.
- Closes the frame at a fixed length, or aborts it on line-idle timeout.
- Sits between the Manchester state machine and data_multiplex; replaces the raw first-rising-edge start-of-transmission.

Parameters:
PREAMBLE, 8'b1010_1011, preamble pattern, MSB received first
PREAMBLE_LEN, 8, number of preamble bits compared (1..8; low PREAMBLE_LEN bits of PREAMBLE used)
PAYLOAD_BITS, 64, payload bits per frame (1..256)
IDLE_TIMEOUT, 1000, clock cycles with no line edge that abort a frame in progress (1..65535)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
serial_clock  in  1  decoded bit clock (level); a bit is valid on its 0->1 transition
serial_data  in  1  decoded bit value, sampled on the serial_clock 0->1 cycle
line_activity  in  1  high in any cycle with a raw input edge (pos_edge | neg_edge)
transmission_begin  out  1  one-cycle pulse: preamble matched, payload starts
payload_clock  out  1  one-cycle strobe per payload bit
payload_data  out  1  payload bit, valid when payload_clock=1
bit_index  out  8  index of the next payload bit expected (0..PAYLOAD_BITS-1)
frame_active  out  1  high while in PAYLOAD state
frame_done  out  1  one-cycle pulse after the last payload bit
timeout_error  out  1  sticky abort flag; cleared on next transmission_begin or reset

Behaviour:
- Bit strobe detection:
  - Internal register holds the previous serial_clock.
  - bit_strobe = serial_clock & ~prev; it is combinational inside the block.
  - All outputs are registered, so each response appears 1 cycle after the bit_strobe cycle.
- Reset (clock edge with reset=1):
  - state=HUNT; shift register, fill counter, bit_index and idle counter all 0.
  - Every output is 0, including timeout_error.
  - Reset overrides every event in the same cycle.
  - Reset mid-frame aborts silently: no frame_done, no timeout_error.
- State HUNT:
  - On bit_strobe: shift = {shift[6:0], serial_data}; fill counter saturates at PREAMBLE_LEN.
  - The match compares the updated shift's low PREAMBLE_LEN bits with PREAMBLE and requires fill counter >= PREAMBLE_LEN, counting the current bit.
  - On match: transmission_begin=1 for 1 cycle; go to PAYLOAD; bit_index=0; timeout_error=0; idle counter=0.
  - The matching bit itself is not forwarded as payload.
  - No timeout counting in HUNT.
- State PAYLOAD:
  - frame_active=1.
  - On bit_strobe: payload_clock=1 and payload_data=serial_data for 1 cycle; bit_index increments.
  - When the strobe carries bit PAYLOAD_BITS-1: frame_done=1 for 1 cycle, in the same cycle as that bit's payload_clock. Then state=HUNT, bit_index=0, frame_active=0, shift and fill counter cleared.
  - The idle counter increments each cycle with line_activity=0 and clears on line_activity=1.
  - When the idle counter reaches IDLE_TIMEOUT: timeout_error=1; state=HUNT; bit_index=0; shift and fill counter cleared; no frame_done.
- Simultaneous bit_strobe and timeout in one cycle: the strobe is processed, the idle counter clears, no timeout.
- transmission_begin and frame_done never assert in the same cycle.
- A preamble pattern inside the payload does not resynchronise: matching happens only in HUNT.
- Widths:
  - bit_index: 8-bit unsigned, never exceeds PAYLOAD_BITS-1 while frame_active.
  - Idle counter: 16-bit, saturating.
  - Fill counter: 4-bit, saturating.
- serial_clock held high indefinitely produces exactly one strobe.

Test Plan:
- Reset, then bits 1,0,1,0,1,0,1,1 on serial_clock rising edges -> transmission_begin pulses exactly 1 cycle after the 8th strobe; frame_active=1; bit_index=0; no payload_clock yet.
- After sync, 64 bits alternating 0x5A pattern -> 64 payload_clock pulses with payload_data matching; bit_index counts 0..63; frame_done together with the 64th payload_clock; frame_active=0 next cycle.
- Preamble 10101011 embedded in payload bits 10..17 -> no transmission_begin; frame still completes at the 64th bit.
- Sync, 5 payload bits, then line_activity=0 for 1000 cycles -> timeout_error=1 on cycle 1000; state HUNT; no frame_done; next valid preamble clears timeout_error with transmission_begin.
- Only 7 bits after reset matching the low 7 preamble bits (0101011) -> no transmission_begin (fill check); the 8th correct bit triggers sync.
- reset=1 at payload bit 30 -> all outputs 0 next cycle; subsequent payload-like bits ignored until a full preamble is seen.

Source files
------------

// File: rtl/frame_sync_controller.sv
// frame_sync_controller: BEP frame sequencer on the decoded Manchester bit stream.
// Hunts a preamble, gates and counts payload bits, closes on length or idle timeout.
//
// Ports:
//   clock              system clock
//   reset              synchronous, active-high reset
//   serial_clock       decoded bit clock (level), bit valid on its 0->1 transition
//   serial_data        decoded bit value, sampled in the serial_clock 0->1 cycle
//   line_activity      high in any cycle with a raw line edge
//   transmission_begin one-cycle pulse, preamble matched, payload starts
//   payload_clock      one-cycle strobe per payload bit
//   payload_data       payload bit, valid with payload_clock
//   bit_index          index of the next payload bit expected
//   frame_active       high while receiving payload
//   frame_done         one-cycle pulse with the last payload bit
//   timeout_error      sticky idle-timeout abort flag
module frame_sync_controller #(
    parameter logic [7:0]  PREAMBLE     = 8'b1010_1011,
    parameter int unsigned PREAMBLE_LEN = 8,
    parameter int unsigned PAYLOAD_BITS = 64,
    parameter int unsigned IDLE_TIMEOUT = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_clock,
    input  logic       serial_data,
    input  logic       line_activity,
    output logic       transmission_begin,
    output logic       payload_clock,
    output logic       payload_data,
    output logic [7:0] bit_index,
    output logic       frame_active,
    output logic       frame_done,
    output logic       timeout_error
);

    typedef enum logic {
        ST_HUNT,
        ST_PAYLOAD
    } state_t;

    localparam logic [7:0]  PRE_MASK   = 8'((1 << PREAMBLE_LEN) - 1);
    localparam logic [7:0]  PRE_MATCH  = PREAMBLE & PRE_MASK;
    localparam logic [3:0]  FILL_MAX   = 4'(PREAMBLE_LEN);
    localparam logic [7:0]  LAST_INDEX = 8'(PAYLOAD_BITS - 1);
    localparam logic [15:0] IDLE_LIMIT = 16'(IDLE_TIMEOUT);

    state_t      state;
    logic        prev_sclk;
    // Only the last 7 bits need storing; the 8th is the bit arriving now.
    logic [6:0]  shift_hist;
    logic [3:0]  fill_cnt;
    logic [15:0] idle_cnt;

    logic        bit_strobe;
    logic [7:0]  shift_next;
    logic [3:0]  fill_next;
    logic        preamble_hit;
    logic [15:0] idle_next;
    logic        idle_expired;
    logic        last_bit;

    assign bit_strobe = serial_clock & ~prev_sclk;
    assign shift_next = {shift_hist, serial_data};

    assign fill_next = (fill_cnt >= FILL_MAX) ? FILL_MAX
                                              : fill_cnt + 4'd1;

    // Fill check stops a short history padded with reset zeros
    // from matching a preamble whose leading bits are zero.
    assign preamble_hit = ((shift_next & PRE_MASK) == PRE_MATCH)
                          && (fill_next >= FILL_MAX);

    assign idle_next = line_activity        ? 16'd0 :
                       (idle_cnt == 16'hFFFF) ? idle_cnt
                                              : idle_cnt + 16'd1;

    assign idle_expired = (idle_next >= IDLE_LIMIT);
    assign last_bit     = (bit_index == LAST_INDEX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= ST_HUNT;
            prev_sclk          <= 1'b0;
            shift_hist         <= '0;
            fill_cnt           <= '0;
            idle_cnt           <= '0;
            bit_index          <= '0;
            transmission_begin <= 1'b0;
            payload_clock      <= 1'b0;
            payload_data       <= 1'b0;
            frame_active       <= 1'b0;
            frame_done         <= 1'b0;
            timeout_error      <= 1'b0;
        end else begin
            prev_sclk          <= serial_clock;
            transmission_begin <= 1'b0;
            payload_clock      <= 1'b0;
            payload_data       <= 1'b0;
            frame_done         <= 1'b0;

            unique case (state)
                ST_HUNT: begin
                    idle_cnt <= '0;
                    if (bit_strobe) begin
                        if (preamble_hit) begin
                            // The matching bit is consumed, not forwarded.
                            state              <= ST_PAYLOAD;
                            transmission_begin <= 1'b1;
                            frame_active       <= 1'b1;
                            bit_index          <= '0;
                            timeout_error      <= 1'b0;
                            shift_hist         <= '0;
                            fill_cnt           <= '0;
                        end else begin
                            shift_hist <= shift_next[6:0];
                            fill_cnt   <= fill_next;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (bit_strobe) begin
                        // A bit arriving wins over a coincident timeout.
                        payload_clock <= 1'b1;
                        payload_data  <= serial_data;
                        idle_cnt      <= '0;
                        if (last_bit) begin
                            state        <= ST_HUNT;
                            frame_done   <= 1'b1;
                            frame_active <= 1'b0;
                            bit_index    <= '0;
                            shift_hist   <= '0;
                            fill_cnt     <= '0;
                        end else begin
                            bit_index <= bit_index + 8'd1;
                        end
                    end else if (idle_expired) begin
                        state         <= ST_HUNT;
                        timeout_error <= 1'b1;
                        frame_active  <= 1'b0;
                        bit_index     <= '0;
                        idle_cnt      <= '0;
                        shift_hist    <= '0;
                        fill_cnt      <= '0;
                    end else begin
                        idle_cnt <= idle_next;
                    end
                end

                default: begin
                    state        <= ST_HUNT;
                    frame_active <= 1'b0;
                    bit_index    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sync_controller.sv
// tb_frame_sync_controller: scoreboard bench for frame_sync_controller.
// Stimulus pushes expected events; a negedge monitor pops and compares them.
module tb_frame_sync_controller;

    localparam int K_BEGIN = 1;
    localparam int K_BIT   = 2;
    localparam int K_TO    = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       serial_clock;
    logic       serial_data;
    logic       line_activity;
    logic       transmission_begin;
    logic       payload_clock;
    logic       payload_data;
    logic [7:0] bit_index;
    logic       frame_active;
    logic       frame_done;
    logic       timeout_error;

    frame_sync_controller dut (
        .clock              (clock),
        .reset              (reset),
        .serial_clock       (serial_clock),
        .serial_data        (serial_data),
        .line_activity      (line_activity),
        .transmission_begin (transmission_begin),
        .payload_clock      (payload_clock),
        .payload_data       (payload_data),
        .bit_index          (bit_index),
        .frame_active       (frame_active),
        .frame_done         (frame_done),
        .timeout_error      (timeout_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        bit         data;
        logic [7:0] idx;
        bit         done;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Monitor: every visible DUT event must match the next expectation.
    bit to_q   = 1'b0;
    bit done_q = 1'b0;
    always @(negedge clock) begin
        int   seen;
        exp_t e;
        seen = 0;
        if (transmission_begin)              seen = K_BEGIN;
        else if (payload_clock)              seen = K_BIT;
        else if (timeout_error && !to_q)     seen = K_TO;
        to_q = timeout_error;
        if (done_q) check("active_after_done", frame_active, 0);
        done_q = frame_done;
        if (frame_done && !payload_clock)
            check("stray_frame_done", frame_done, 0);
        if (seen != 0) begin
            if (sb.size() == 0) begin
                check("unexpected_event", seen, 0);
            end else begin
                e = sb.pop_front();
                check("event_kind", seen, e.kind);
                check("event_cycle", cyc, e.cyc);
                case (seen)
                    K_BEGIN: begin
                        check("begin_active", frame_active, 1);
                        check("begin_index", bit_index, 0);
                        check("begin_timeout_clr", timeout_error, 0);
                        check("begin_not_done", frame_done, 0);
                    end
                    K_BIT: begin
                        check("payload_data", payload_data, e.data);
                        check("bit_index", bit_index, e.idx);
                        check("frame_done", frame_done, e.done);
                        check("bit_active", frame_active, !e.done);
                    end
                    default: begin
                        check("to_active", frame_active, 0);
                        check("to_index", bit_index, 0);
                        check("to_not_done", frame_done, 0);
                    end
                endcase
            end
        end
    end

    task automatic send_bit(input bit b, input int kind, input int i);
        exp_t e;
        @(negedge clock);
        serial_data   = b;
        serial_clock  = 1'b1;
        line_activity = 1'b1;
        if (kind != 0) begin
            e.kind = kind;
            e.data = b;
            e.cyc  = cyc + 1;
            e.done = (kind == K_BIT) && (i == 63);
            e.idx  = (kind == K_BIT) ? 8'((i + 1) % 64) : 8'd0;
            sb.push_back(e);
        end
        @(negedge clock);
        serial_clock = 1'b0;
        @(negedge clock);
    endtask

    task automatic send_preamble();
        logic [7:0] p;
        p = 8'b1010_1011;
        for (int i = 0; i < 8; i++)
            send_bit(p[7-i], (i == 7) ? K_BEGIN : 0, 0);
    endtask

    task automatic send_payload(input logic [63:0] p, input int n);
        for (int i = 0; i < n; i++)
            send_bit(p[63-i], K_BIT, i);
    endtask

    task automatic send_hunt(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++)
            send_bit(p[n-1-i], 0, 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_begin"},   transmission_begin, 0);
        check({tag, "_pclk"},    payload_clock, 0);
        check({tag, "_pdata"},   payload_data, 0);
        check({tag, "_index"},   bit_index, 0);
        check({tag, "_active"},  frame_active, 0);
        check({tag, "_done"},    frame_done, 0);
        check({tag, "_timeout"}, timeout_error, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [63:0] emb;
        reset         = 1'b1;
        serial_clock  = 1'b0;
        serial_data   = 1'b0;
        line_activity = 1'b1;
        repeat (3) @(negedge clock);
        check_quiet("reset");
        reset = 1'b0;

        // Sync then a 0x5A frame.
        send_preamble();
        send_payload({8{8'h5A}}, 64);

        // Preamble embedded at payload bits 10..17 must not resync.
        emb = 64'hF000_0000_0000_000F | (64'hAB << 46);
        send_preamble();
        send_payload(emb, 64);

        // Low 7 preamble bits alone after reset: no sync.
        do_reset();
        send_hunt(16'b0101011, 7);
        send_preamble();

        // 5 payload bits then line idle until timeout.
        send_payload(64'hA800_0000_0000_0000, 5);
        @(negedge clock);
        line_activity = 1'b0;
        e.kind = K_TO;
        e.data = 1'b0;
        e.idx  = 8'd0;
        e.done = 1'b0;
        e.cyc  = cyc + 1000;
        sb.push_back(e);
        repeat (1010) @(negedge clock);
        check("timeout_sticky", timeout_error, 1);
        line_activity = 1'b1;

        // Next preamble clears the timeout flag.
        send_preamble();

        // Reset at payload bit 30, coinciding with a strobe.
        send_payload(64'h3C3C_3C3C_3C3C_3C3C, 30);
        @(negedge clock);
        serial_data  = 1'b1;
        serial_clock = 1'b1;
        reset        = 1'b1;
        @(negedge clock);
        check_quiet("midreset");
        reset        = 1'b0;
        serial_clock = 1'b0;

        // Payload-like noise is ignored until a full preamble.
        send_hunt(16'hFF00, 16);
        send_preamble();
        send_payload({8{8'hC3}}, 64);

        repeat (5) @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
